// File: rtl/div_seq_param_if.sv
// Handshake and operand/result bundle for the sequential divider.
interface div_seq_param_if #(
   parameter int W = 8
);
   logic         start;
   logic         mode;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic [W-1:0] z;
   logic [W-1:0] r;
   logic         busy;
   logic         done;
   logic         dbz;
   logic         ovf;

   modport master (
      output start, mode, x, y,
      input  z, r, busy, done, dbz, ovf
   );

   modport slave (
      input  start, mode, x, y,
      output z, r, busy, done, dbz, ovf
   );
endinterface

// File: rtl/div_seq_param.sv
// Sequential radix-2 non-restoring signed divider, W-bit operands,
// sign-magnitude or two's-complement selected per operation.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; operands latched and converted on accept
// RUN    | one quotient bit per cycle, MSB first, W cycles
// FIN    | remainder correction, sign application, results + done
module div_seq_param #(
   parameter int W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   div_seq_param_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;
   localparam int         CW     = $clog2(W + 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [W:0]    p;
   logic [W-1:0]  q;
   logic [W-1:0]  d;
   logic [W-1:0]  x_lat;
   logic          mode_lat;
   logic          sx;
   logic          sy;

   logic [W-1:0]  z_q;
   logic [W-1:0]  r_q;
   logic          done_q;
   logic          dbz_q;
   logic          ovf_q;

   logic [W-1:0]  x_mag;
   logic [W-1:0]  y_mag;
   logic [W:0]    p_sh;
   logic [W:0]    p_nx;
   logic [W-1:0]  q_nx;
   logic [W-1:0]  r_mag;
   logic          sz;
   logic [W-1:0]  z_o;
   logic [W-1:0]  r_o;
   logic          dbz_o;
   logic          ovf_o;

   // Operand magnitudes from the live inputs; only used on the accepting edge.
   always_comb begin
      x_mag = '0;
      y_mag = '0;
      if (bus.mode) begin
         x_mag = bus.x[W-1] ? (~bus.x + W'(1)) : bus.x;
         y_mag = bus.y[W-1] ? (~bus.y + W'(1)) : bus.y;
      end else begin
         x_mag = {1'b0, bus.x[W-2:0]};
         y_mag = {1'b0, bus.y[W-2:0]};
      end
   end

   // One non-restoring step; the partial remainder never leaves [-d, d).
   always_comb begin
      p_sh = {p[W-1:0], q[W-1]};
      p_nx = p[W] ? (p_sh + {1'b0, d}) : (p_sh - {1'b0, d});
      q_nx = {q[W-2:0], ~p_nx[W]};
   end

   // Final remainder correction and output encoding, consumed in FIN.
   always_comb begin
      r_mag = p[W] ? (p[W-1:0] + d) : p[W-1:0];
      sz    = sx ^ sy;
      z_o   = '0;
      r_o   = '0;
      dbz_o = 1'b0;
      ovf_o = 1'b0;
      if (d == '0) begin
         z_o   = '1;
         r_o   = x_lat;
         dbz_o = 1'b1;
      end else if (mode_lat) begin
         z_o   = sz ? -q : q;
         r_o   = sx ? -r_mag : r_mag;
         // only -2^(W-1) / -1 yields a positive quotient of 2^(W-1)
         ovf_o = ~sz & q[W-1];
      end else begin
         // zero magnitudes drop the sign so -0 never appears
         z_o = {sz & (|q[W-2:0]), q[W-2:0]};
         r_o = {sx & (|r_mag[W-2:0]), r_mag[W-2:0]};
      end
   end

   // Control FSM, iteration datapath and registered results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         p        <= '0;
         q        <= '0;
         d        <= '0;
         x_lat    <= '0;
         mode_lat <= 1'b0;
         sx       <= 1'b0;
         sy       <= 1'b0;
         z_q      <= '0;
         r_q      <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  x_lat    <= bus.x;
                  mode_lat <= bus.mode;
                  sx       <= bus.x[W-1];
                  sy       <= bus.y[W-1];
                  q        <= x_mag;
                  d        <= y_mag;
                  p        <= '0;
                  cnt      <= '0;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               p   <= p_nx;
               q   <= q_nx;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(W - 1)) begin
                  state <= S_FIN;
               end
            end
            S_FIN: begin
               z_q    <= z_o;
               r_q    <= r_o;
               dbz_q  <= dbz_o;
               ovf_q  <= ovf_o;
               done_q <= 1'b1;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = (state != S_IDLE);
   assign bus.done = done_q;
   assign bus.z    = z_q;
   assign bus.r    = r_q;
   assign bus.dbz  = dbz_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_div_seq_param.sv
// Bench for div_seq_param: W=8 directed vectors with literal expectations
// and W=16 randomised traffic, both checked every cycle against an
// arithmetic reference model.
module tb_div_seq_param;

   localparam int N_RAND = 1000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   div_seq_param_if #(.W(8))  b8 ();
   div_seq_param_if #(.W(16)) b16 ();

   div_seq_param #(.W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
   div_seq_param #(.W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

   always #5 clk = ~clk;

   // Reference: decode operands to integers, divide with truncation toward
   // zero, re-encode. Returns {dbz, ovf, z[31:0], r[31:0]}.
   function automatic logic [65:0] ref_div(input int w, input bit md,
                                           input longint xv, input longint yv);
      longint half, full, xi, yi, qi, ri, ez, er;
      bit     edz, eov;
      half = longint'(1) << (w - 1);
      full = half * 2;
      edz  = 1'b0;
      eov  = 1'b0;
      ez   = 0;
      er   = 0;
      if (!md) begin
         xi = xv & (half - 1);
         if ((xv & half) != 0) xi = -xi;
         yi = yv & (half - 1);
         if ((yv & half) != 0) yi = -yi;
      end else begin
         xi = (xv >= half) ? xv - full : xv;
         yi = (yv >= half) ? yv - full : yv;
      end
      if (yi == 0) begin
         ez  = full - 1;
         er  = xv;
         edz = 1'b1;
      end else begin
         qi = xi / yi;
         ri = xi % yi;
         if (md) begin
            eov = (qi == half);
            ez  = qi & (full - 1);
            er  = ri & (full - 1);
         end else begin
            ez = (qi < 0) ? (half | -qi) : qi;
            er = (ri < 0) ? (half | -ri) : ri;
         end
      end
      return {edz, eov, ez[31:0], er[31:0]};
   endfunction

   // Model state: cycles left until done, pending and last published results.
   int          m8_left   = 0;
   logic        m8_done   = 1'b0;
   logic [65:0] m8_pres   = '0;
   logic [65:0] m8_exp    = '0;
   int          m16_left  = 0;
   logic        m16_done  = 1'b0;
   logic [65:0] m16_pres  = '0;
   logic [65:0] m16_exp   = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m8_left <= 0;
         m8_done <= 1'b0;
         m8_exp  <= '0;
      end else begin
         m8_done <= 1'b0;
         if (m8_left != 0) begin
            m8_left <= m8_left - 1;
            if (m8_left == 1) begin
               m8_done <= 1'b1;
               m8_exp  <= m8_pres;
            end
         end else if (b8.start === 1'b1) begin
            m8_left <= 8 + 1;
            m8_pres <= ref_div(8, b8.mode, longint'(b8.x), longint'(b8.y));
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m16_left <= 0;
         m16_done <= 1'b0;
         m16_exp  <= '0;
      end else begin
         m16_done <= 1'b0;
         if (m16_left != 0) begin
            m16_left <= m16_left - 1;
            if (m16_left == 1) begin
               m16_done <= 1'b1;
               m16_exp  <= m16_pres;
            end
         end else if (b16.start === 1'b1) begin
            m16_left <= 16 + 1;
            m16_pres <= ref_div(16, b16.mode, longint'(b16.x), longint'(b16.y));
         end
      end
   end

   task automatic chk_vec(input string nm, input logic [67:0] act, input logic [67:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
      end
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
      end
   endtask

   // Cycle-by-cycle compare of {busy, done, dbz, ovf, z, r} against the model.
   always @(negedge clk) begin
      chk_vec("cyc8",
              {b8.busy, b8.done, b8.dbz, b8.ovf, 32'(b8.z), 32'(b8.r)},
              {m8_left != 0, m8_done, m8_exp});
      chk_vec("cyc16",
              {b16.busy, b16.done, b16.dbz, b16.ovf, 32'(b16.z), 32'(b16.r)},
              {m16_left != 0, m16_done, m16_exp});
   end

   task automatic wait_done8(output int lat);
      lat = 0;
      while (b8.done !== 1'b1 && lat < 40) begin
         @(posedge clk); #2;
         lat++;
      end
   endtask

   // One W=8 operation with literal expectations; poke>0 re-pulses start
   // with a different dividend that many cycles after acceptance.
   task automatic op8(input string nm, input bit md, input logic [7:0] xv,
                      input logic [7:0] yv, input logic [7:0] ez, input logic [7:0] er,
                      input bit edz, input bit eov, input int poke);
      int lat;
      @(posedge clk); #2;
      b8.start = 1'b1; b8.mode = md; b8.x = xv; b8.y = yv;
      @(posedge clk); #2;
      b8.start = 1'b0; b8.x = ~xv; b8.y = 8'h01; b8.mode = ~md;
      lat = 0;
      while (b8.done !== 1'b1 && lat < 40) begin
         @(posedge clk); #2;
         lat++;
         b8.start = (poke != 0 && lat == poke);
      end
      b8.start = 1'b0;
      chk({nm, " latency"}, lat, 9);
      chk({nm, " z"}, b8.z, ez);
      chk({nm, " r"}, b8.r, er);
      chk({nm, " flags"}, {b8.dbz, b8.ovf}, {edz, eov});
   endtask

   int lat_a, ndone, ops, guard, sel;

   initial begin
      b8.start = 0;  b8.mode = 0;  b8.x = '0;  b8.y = '0;
      b16.start = 0; b16.mode = 0; b16.x = '0; b16.y = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset 8", {b8.busy, b8.done, b8.dbz, b8.ovf, b8.z, b8.r}, 0);
      chk("reset 16", {b16.busy, b16.done, b16.dbz, b16.ovf, b16.z, b16.r}, 0);
      #1 rst_n = 1'b1;

      op8("sm -7/2",    0, 8'h87, 8'h02, 8'h83, 8'h81, 0, 0, 0);
      op8("tc -7/2",    1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 0, 0, 0);
      op8("tc 100/-7",  1, 8'h64, 8'hF9, 8'hF2, 8'h02, 0, 0, 0);
      op8("dbz sm y0",  0, 8'h2A, 8'h00, 8'hFF, 8'h2A, 1, 0, 0);
      op8("dbz sm -0",  0, 8'h2A, 8'h80, 8'hFF, 8'h2A, 1, 0, 0);
      op8("dbz tc y0",  1, 8'h2A, 8'h00, 8'hFF, 8'h2A, 1, 0, 0);
      op8("tc ovf",     1, 8'h80, 8'hFF, 8'h80, 8'h00, 0, 1, 0);
      op8("tc -128/1",  1, 8'h80, 8'h01, 8'h80, 8'h00, 0, 0, 0);
      op8("sm no -0",   0, 8'h80, 8'h05, 8'h00, 8'h00, 0, 0, 0);
      op8("sm -7/-5",   0, 8'h87, 8'h85, 8'h01, 8'h82, 0, 0, 0);
      op8("tc small",   1, 8'hF9, 8'h14, 8'h00, 8'hF9, 0, 0, 0);
      op8("sm small",   0, 8'h85, 8'h14, 8'h00, 8'h85, 0, 0, 0);
      op8("repulse",    1, 8'h64, 8'hF9, 8'hF2, 8'h02, 0, 0, 3);

      // start held high: second op accepted on the done cycle
      @(posedge clk); #2;
      b8.start = 1'b1; b8.mode = 1'b0; b8.x = 8'h87; b8.y = 8'h02;
      @(posedge clk); #2;
      wait_done8(lat_a);
      chk("held lat1", lat_a, 9);
      chk("held z1", b8.z, 8'h83);
      chk("held busy gap", b8.busy, 0);
      b8.mode = 1'b1; b8.x = 8'hF9; b8.y = 8'h02;
      @(posedge clk); #2;
      chk("held busy again", b8.busy, 1);
      wait_done8(lat_a);
      b8.start = 1'b0;
      chk("held lat2", lat_a, 9);
      chk("held z2", b8.z, 8'hFD);
      chk("held r2", b8.r, 8'hFF);

      // reset at iteration 4 aborts silently
      @(posedge clk); #2;
      b8.start = 1'b1; b8.mode = 1'b1; b8.x = 8'h64; b8.y = 8'h07;
      @(posedge clk); #2;
      b8.start = 1'b0;
      repeat (4) begin @(posedge clk); #2; end
      rst_n = 1'b0;
      #1;
      chk("mid reset", {b8.busy, b8.done, b8.dbz, b8.ovf, b8.z, b8.r}, 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      ndone = 0;
      repeat (14) begin
         @(posedge clk); #2;
         if (b8.done === 1'b1) ndone++;
      end
      chk("no done after abort", ndone, 0);
      op8("after reset", 1, 8'h64, 8'h07, 8'h0E, 8'h02, 0, 0, 0);

      // W=16 random traffic, start held, new operands on every idle/done cycle
      for (int md = 0; md < 2; md++) begin
         ops = 0;
         guard = 0;
         b16.mode = md[0];
         b16.start = 1'b1;
         while (ops < N_RAND && guard < N_RAND * 30) begin
            @(posedge clk); #2;
            guard++;
            if (b16.done === 1'b1) ops++;
            if (b16.busy === 1'b0) begin
               sel = $urandom_range(0, 9);
               b16.x = 16'($urandom);
               b16.y = 16'($urandom);
               if (sel == 0) b16.y = 16'h0000;
               if (sel == 1) b16.x = 16'h8000;
               if (sel == 2) b16.y = 16'hFFFF;
               if (sel == 3) b16.y = 16'h8000;
               if (sel == 4) b16.y = 16'($urandom_range(1, 9));
               if (ops >= N_RAND) b16.start = 1'b0;
            end
         end
         b16.start = 1'b0;
         chk("rand16 ops", ops, N_RAND);
         repeat (20) @(posedge clk);
      end

      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3_000_000;
      n_bad++;
      $display("FAIL watchdog t=%0t got=running want=finished", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
